// File: rtl/dmem_mmio.sv
// Data memory plus LED/switch/cycle-counter I/O behind a one-deep valid/ready response register.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned or reserved-size accesses; otherwise they are aligned down.
module dmem_mmio #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LED_W       = 16,
    parameter int SW_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta, sw_sync;
    logic [31:0]      cnt_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic          accept;
    logic [1:0]    size_eff;
    logic [1:0]    off;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wrep;
    logic [31:0]   mask32;
    logic [31:0]   led_ext, sw_ext, led_new;
    logic [31:0]   raw_word, shifted, load_data;
    logic          is_io;
    logic [1:0]    io_sel;
    logic [AW-1:0] idx;
    logic          do_write;
    logic          unused_bits;

    assign is_io       = req_addr[31];
    assign io_sel      = req_addr[3:2];
    assign idx         = req_addr[AW+1:2];
    assign req_ready   = (state_q == IDLE) || resp_ready;
    assign accept      = req_valid && req_ready;
    assign do_write    = accept && req_we && !err;
    assign unused_bits = ^{req_addr[30:AW+2], led_new};

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path can infer a latch.
        size_eff = req_size;
        off      = req_addr[1:0];
        err      = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        err = (req_size == 2'd3)
           || (req_size == 2'd1 && req_addr[0])
           || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
        if (req_size == 2'd3) size_eff = 2'd2;
        if (size_eff == 2'd1)      off[0] = 1'b0;
        else if (size_eff == 2'd2) off    = 2'b00;
`endif
    end

    // Store lanes: data is replicated so each enabled lane already holds the right bytes.
    always_comb begin
        be   = 4'b1111;
        wrep = req_wdata;
        case (size_eff)
            2'd0: begin
                be   = 4'b0001 << off;
                wrep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be   = 4'b0011 << {off[1], 1'b0};
                wrep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        mask32 = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    always_comb begin
        led_ext              = '0;
        led_ext[LED_W-1:0]   = led_q;
        sw_ext               = '0;
        sw_ext[SW_W-1:0]     = sw_sync;
        led_new              = (led_ext & ~mask32) | (wrep & mask32);
    end

    always_comb begin
        raw_word = mem[idx];
        if (is_io) begin
            case (io_sel)
                2'd0:    raw_word = led_ext;
                2'd1:    raw_word = sw_ext;
                2'd2:    raw_word = cnt_q;
                default: raw_word = '0;
            endcase
        end
        shifted = raw_word >> {off, 3'b000};
        case (size_eff)
            2'd0:    load_data = req_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'b0, shifted[7:0]};
            2'd1:    load_data = req_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // NOTE: the RAM array has no reset; clearing it would rule out block-RAM mapping and is not required.
    always_ff @(posedge clk) begin
        if (do_write && !is_io) begin
            if (be[0]) mem[idx][7:0]   <= wrep[7:0];
            if (be[1]) mem[idx][15:8]  <= wrep[15:8];
            if (be[2]) mem[idx][23:16] <= wrep[23:16];
            if (be[3]) mem[idx][31:24] <= wrep[31:24];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            cnt_q   <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            cnt_q   <= cnt_q + 32'd1;
            if (do_write && is_io && io_sel == 2'd0)
                led_q <= led_new[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            resp_rdata_q <= (req_we || err) ? 32'd0 : load_data;
            resp_err_q   <= err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (resp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign led_out    = led_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomised bench for dmem_mmio against a byte-level reference model and response scoreboard.
// Honours DMEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dmem_mmio;

    localparam int DEPTH = 4096;
    localparam int LED_W = 16;
    localparam int SW_W  = 16;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] LED_MASK = (32'h1 << LED_W) - 32'h1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_we, req_signed;
    logic [1:0]       req_size;
    logic [31:0]      req_addr, req_wdata;
    logic             resp_valid, resp_ready, resp_err;
    logic [31:0]      resp_rdata;
    logic [SW_W-1:0]  sw_in;
    logic [LED_W-1:0] led_out;

    dmem_mmio #(.DEPTH_WORDS(DEPTH), .LED_W(LED_W), .SW_W(SW_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .sw_in      (sw_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    logic [7:0]  mbytes [DEPTH*4];
    logic [31:0] led_m, sw_m;
    int unsigned tb_cycles = 0;
    rsp_t        exp_q[$];
    req_t        cur;
    bit          have_req;
    int          rr_force;
    logic [31:0] last_rdata;
    logic        last_err;
    int          n_vec = 0;
    int          n_bad = 0;

    // Free-running cycle count since reset release, the model's view of the counter.
    always @(posedge clk or negedge rst)
        if (!rst) tb_cycles <= 0;
        else      tb_cycles <= tb_cycles + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rsp_t model(input req_t r);
        rsp_t        res;
        int          n;
        logic [31:0] a, v, word;
        int unsigned base, lane;
        n   = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        res = '{32'd0, 1'b0};
        if (TRAP && (r.size == 2'd3 || (int'(r.addr[1:0]) % n) != 0)) begin
            res.err = 1'b1;
            return res;
        end
        a = r.addr & ~(n - 1);
        v = 32'd0;
        if (!a[31]) begin
            base = a & (DEPTH*4 - 1);
            for (int i = 0; i < n; i++)
                if (r.we) mbytes[base + i] = r.wdata[8*i +: 8];
                else      v[8*i +: 8] = mbytes[base + i];
        end else begin
            lane = a[1:0];
            case (a[3:2])
                2'd0:    word = led_m;
                2'd1:    word = sw_m;
                2'd2:    word = tb_cycles;
                default: word = 32'd0;
            endcase
            for (int i = 0; i < n; i++)
                if (r.we) word[8*(lane + i) +: 8] = r.wdata[8*i +: 8];
                else      v[8*i +: 8] = word[8*(lane + i) +: 8];
            if (r.we && a[3:2] == 2'd0) led_m = word & LED_MASK;
        end
        if (!r.we && r.sgn && n < 4 && v[8*n - 1])
            v = v | ~((32'h1 << (8*n)) - 32'h1);
        res.rdata = r.we ? 32'd0 : v;
        return res;
    endfunction

    // One clock: drive at the falling edge, compare outputs, update scoreboard, step past the rising edge.
    task automatic cycle();
        bit exp_rdy;
        resp_ready = (rr_force == 2) ? 1'b1 : (rr_force == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (have_req) begin
            req_valid  = 1'b1;
            req_we     = cur.we;
            req_size   = cur.size;
            req_signed = cur.sgn;
            req_addr   = cur.addr;
            req_wdata  = cur.wdata;
        end else begin
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        #1;
        check("resp_valid", resp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("resp_rdata", resp_rdata, exp_q[0].rdata);
            check("resp_err", resp_err, exp_q[0].err);
        end
        exp_rdy = (exp_q.size() == 0) || resp_ready;
        check("req_ready", req_ready, exp_rdy);
        check("led_out", led_out, led_m);
        if (exp_q.size() != 0 && resp_ready) begin
            last_rdata = resp_rdata;
            last_err   = resp_err;
            void'(exp_q.pop_front());
        end
        if (have_req && exp_rdy) begin
            exp_q.push_back(model(cur));
            have_req = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cur      = '{we, size, sgn, addr, wdata};
        have_req = 1'b1;
        for (int k = 0; k < 200 && have_req; k++) cycle();
        check("issue_timeout", 32'(have_req), 32'd0);
        have_req = 1'b0;
    endtask

    task automatic drain();
        rr_force = 2;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
        rr_force = 0;
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        issue(1'b1, size, 1'b0, addr, wdata);
        drain();
    endtask

    task automatic ld(input logic [1:0] size, input bit sgn, input logic [31:0] addr);
        issue(1'b0, size, sgn, addr, 32'd0);
        drain();
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; sw_in = '0;
        led_m = 32'd0; sw_m = 32'd0; rr_force = 0; have_req = 1'b0;
        last_rdata = '0; last_err = 1'b0;
        #12;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_led", led_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        st(2'd2, 32'h10, 32'h1234_5678);
        ld(2'd0, 1'b1, 32'h13);  check("ld_b_s_13", last_rdata, 32'h0000_0012);
        ld(2'd1, 1'b1, 32'h12);  check("ld_h_s_12", last_rdata, 32'h0000_1234);

        st(2'd2, 32'h20, 32'hFFFF_FFFF);
        st(2'd0, 32'h21, 32'h0000_0080);
        ld(2'd2, 1'b0, 32'h20);  check("ld_w_20", last_rdata, 32'hFFFF_80FF);
        ld(2'd0, 1'b1, 32'h21);  check("ld_b_s_21", last_rdata, 32'hFFFF_FF80);
        ld(2'd0, 1'b0, 32'h21);  check("ld_b_u_21", last_rdata, 32'h0000_0080);

        st(2'd2, 32'h8000_0000, 32'h0000_BEEF);
        check("led_beef", led_out, 32'h0000_BEEF);
        sw_in = 16'h00A5;
        repeat (3) cycle();
        sw_m = 32'h0000_00A5;
        ld(2'd2, 1'b0, 32'h8000_0004); check("sw_a5", last_rdata, 32'h0000_00A5);
        ld(2'd2, 1'b0, 32'h8000_0008);
        ld(2'd2, 1'b0, 32'h8000_000C); check("io_reserved", last_rdata, 32'd0);

        // Backpressure: response held for three cycles with a second request waiting.
        rr_force = 1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        cur      = '{1'b0, 2'd1, 1'b0, 32'h22, 32'd0};
        have_req = 1'b1;
        repeat (3) cycle();
        rr_force = 2;
        cycle();
        check("hold_accepted", 32'(have_req), 32'd0);
        have_req = 1'b0;
        drain();

        st(2'd2, 32'h0, 32'hCAFE_F00D);
        st(2'd2, 32'h2, 32'hA1B2_C3D4);
        check("mis_err", last_err, TRAP);
        ld(2'd2, 1'b0, 32'h0);
        check("mis_word0", last_rdata, TRAP ? 32'hCAFE_F00D : 32'hA1B2_C3D4);

        st(2'd2, DEPTH*4, 32'h5A5A_1234);
        ld(2'd2, 1'b0, 32'h0); check("alias_wrap", last_rdata, 32'h5A5A_1234);

        for (int w = 0; w < 16; w++) st(2'd2, 32'(w*4), $urandom);

        for (int k = 0; k < 400; k++) begin
            a = $urandom;
            if ($urandom_range(0, 4) == 0) a = a | 32'h8000_0000;
            else                           a = {1'b0, a[30:14], 8'b0, a[5:0]};
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) cycle();
        end
        drain();

        // Reset while a response is pending and not yet taken.
        rr_force = 1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        req_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("midrst_valid", resp_valid, 0);
        check("midrst_rdata", resp_rdata, 0);
        check("midrst_ready", req_ready, 1);
        check("midrst_led", led_out, 0);
        exp_q.delete();
        led_m = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        rr_force = 0;
        ld(2'd2, 1'b0, 32'h10);
        ld(2'd2, 1'b0, 32'h8000_0008);
        ld(2'd2, 1'b0, 32'h8000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
